// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: pixel divider, PosX/PosY counters, registered syncs and strobes.
// Optional macro VGA_SYNC_PIPE_ALIGN_EN delays HSYNC/VSYNC/VideoOn by two CLK to match the pointer stage.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       VideoOn,
  output logic       PixelTick,
  output logic       FrameStart
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] Y_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_VIS11 = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS11 = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_LAST = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_FIRST = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_LAST = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [9:0]       xNext;
  logic [9:0]       yNext;
  logic             hSyncNext;
  logic             vSyncNext;
  logic             videoOnNext;
  logic             frameNext;
  logic             hSyncCore;
  logic             vSyncCore;
  logic             videoOnCore;

  // Next raster position plus the sync/video levels it implies, so every output updates in step.
  always_comb begin
    tick  = (div == DIV_LAST);
    xNext = PosX;
    yNext = PosY;
    if (tick) begin
      if (PosX == X_LAST) begin
        xNext = '0;
        yNext = (PosY == Y_LAST) ? '0 : PosY + 10'd1;
      end else begin
        xNext = PosX + 10'd1;
      end
    end
    hSyncNext   = !(({1'b0, xNext} >= H_SYNC_FIRST) && ({1'b0, xNext} <= H_SYNC_LAST));
    vSyncNext   = !(({1'b0, yNext} >= V_SYNC_FIRST) && ({1'b0, yNext} <= V_SYNC_LAST));
    videoOnNext = ({1'b0, xNext} < H_VIS11) && ({1'b0, yNext} < V_VIS11);
    frameNext   = tick && (xNext == '0) && (yNext == '0);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div         <= '0;
      PosX        <= X_LAST;
      PosY        <= Y_LAST;
      hSyncCore   <= 1'b1;
      vSyncCore   <= 1'b1;
      videoOnCore <= 1'b0;
      PixelTick   <= 1'b0;
      FrameStart  <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      PosX        <= xNext;
      PosY        <= yNext;
      hSyncCore   <= hSyncNext;
      vSyncCore   <= vSyncNext;
      videoOnCore <= videoOnNext;
      PixelTick   <= tick;
      FrameStart  <= frameNext;
    end
  end

`ifdef VGA_SYNC_PIPE_ALIGN_EN
  logic [1:0] hPipe;
  logic [1:0] vPipe;
  logic [1:0] videoPipe;

  // Two extra stages line the syncs up with the pointer register and the ROM read.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hPipe     <= 2'b11;
      vPipe     <= 2'b11;
      videoPipe <= 2'b00;
    end else begin
      hPipe     <= {hPipe[0], hSyncCore};
      vPipe     <= {vPipe[0], vSyncCore};
      videoPipe <= {videoPipe[0], videoOnCore};
    end
  end

  assign HSYNC   = hPipe[1];
  assign VSYNC   = vPipe[1];
  assign VideoOn = videoPipe[1];
`else
  assign HSYNC   = hSyncCore;
  assign VSYNC   = vSyncCore;
  assign VideoOn = videoOnCore;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line-level timing, a shrunken instance for frame-level timing.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_ALIGN_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] posX, posY;
  logic       hSync, vSync, videoOn, pixelTick, frameStart;
  logic [9:0] sPosX, sPosY;
  logic       sHSync, sVSync, sVideoOn, sPixelTick, sFrameStart;

  int compared = 0;
  int mismatched = 0;

  vga_sync_gen dut (
    .CLK(clk), .RESET(rst), .PosX(posX), .PosY(posY), .HSYNC(hSync), .VSYNC(vSync),
    .VideoOn(videoOn), .PixelTick(pixelTick), .FrameStart(frameStart)
  );

  // Small raster: 15x8 totals, CLK_DIV 3, so a frame is 360 CLK.
  vga_sync_gen #(
    .CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dutSmall (
    .CLK(clk), .RESET(rst), .PosX(sPosX), .PosY(sPosY), .HSYNC(sHSync), .VSYNC(sVSync),
    .VideoOn(sVideoOn), .PixelTick(sPixelTick), .FrameStart(sFrameStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic waitTick(output int n);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!pixelTick && n < 20);
    if (!pixelTick) checkOutput("tick_timeout", 32'(pixelTick), 1);
  endtask

  initial begin
    int n, x, cyc, guard;
    int hLow, firstLowX, lastLowX, videoFallX;
    int c, phase, lastX, lastY, fsCount, fs1, fs2, sHLow, sVLow, sVideo, vFirst, vLast;

    // Reset held
    rst = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("rst_posx", 32'(posX), 799);
    checkOutput("rst_posy", 32'(posY), 524);
    checkOutput("rst_hsync", 32'(hSync), 1);
    checkOutput("rst_vsync", 32'(vSync), 1);
    checkOutput("rst_video", 32'(videoOn), 0);
    checkOutput("rst_tick", 32'(pixelTick), 0);
    checkOutput("rst_fs", 32'(frameStart), 0);

    // Release: first tick on the 4th posedge
    rst = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("pre_tick", 32'(pixelTick), 0);
    checkOutput("pre_posx", 32'(posX), 799);
    applyStimulus();
    checkOutput("first_tick", 32'(pixelTick), 1);
    checkOutput("first_fs", 32'(frameStart), 1);
    checkOutput("first_posx", 32'(posX), 0);
    checkOutput("first_posy", 32'(posY), 0);
    applyStimulus();
    checkOutput("fs_one_clk", 32'(frameStart), 0);
    checkOutput("hold_posx", 32'(posX), 0);
    applyStimulus();
    checkOutput("first_video", 32'(videoOn), 1);
    checkOutput("first_hsync", 32'(hSync), 1);
    cyc = 2;
    waitTick(n);
    cyc += n;
    checkOutput("second_tick_gap", 32'(n), 2);
    checkOutput("second_posx", 32'(posX), 1);
    checkOutput("second_fs", 32'(frameStart), 0);

    // One full line
    hLow = 0; firstLowX = -1; lastLowX = -1; videoFallX = -1; guard = 0;
    do begin
      waitTick(n);
      cyc += n;
      x = int'(posX);
      if (x == 656) checkOutput("hsync_lag_pre", 32'(hSync), (LAG == 0) ? 0 : 1);
      if (x == 640) checkOutput("video_lag_pre", 32'(videoOn), (LAG == 0) ? 0 : 1);
      repeat (2) applyStimulus();
      cyc += 2;
      if (!hSync) begin
        hLow++;
        if (firstLowX < 0) firstLowX = x;
        lastLowX = x;
      end
      if (!videoOn && videoFallX < 0) videoFallX = x;
      guard++;
    end while (x != 799 && guard < 900);
    checkOutput("hsync_low_ticks", 32'(hLow), 96);
    checkOutput("hsync_first_x", 32'(firstLowX), 656);
    checkOutput("hsync_last_x", 32'(lastLowX), 751);
    checkOutput("video_fall_x", 32'(videoFallX), 640);
    waitTick(n);
    cyc += n;
    checkOutput("line_wrap_posx", 32'(posX), 0);
    checkOutput("line_wrap_posy", 32'(posY), 1);
    checkOutput("line_cycles", 32'(cyc), 3200);
    checkOutput("line_wrap_fs", 32'(frameStart), 0);

    // Asynchronous reset in the middle of HSYNC
    guard = 0;
    do begin
      waitTick(n);
      guard++;
    end while (posX != 10'd700 && guard < 800);
    repeat (2) applyStimulus();
    checkOutput("mid_hsync_low", 32'(hSync), 0);
    checkOutput("mid_posy", 32'(posY), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_posx", 32'(posX), 799);
    checkOutput("async_posy", 32'(posY), 524);
    checkOutput("async_hsync", 32'(hSync), 1);
    checkOutput("async_video", 32'(videoOn), 0);
    checkOutput("async_tick", 32'(pixelTick), 0);
    repeat (2) applyStimulus();
    rst = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("restart_pre", 32'(pixelTick), 0);
    applyStimulus();
    checkOutput("restart_fs", 32'(frameStart), 1);
    checkOutput("restart_posx", 32'(posX), 0);
    checkOutput("restart_posy", 32'(posY), 0);

    // Frame-level timing on the small raster
    rst = 1'b0;
    repeat (2) applyStimulus();
    rst = 1'b1;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!sFrameStart && n < 10);
    checkOutput("small_first_fs", 32'(n), 3);
    phase = 0; lastX = 0; lastY = 0; fsCount = 0; fs1 = -1; fs2 = -1;
    sHLow = 0; sVLow = 0; sVideo = 0; vFirst = -1; vLast = -1;
    for (c = 1; c <= 720; c++) begin
      applyStimulus();
      if (sFrameStart) begin
        fsCount++;
        if (fsCount == 1) fs1 = c;
        if (fsCount == 2) fs2 = c;
      end
      if (sPixelTick) begin
        if (sPosY == 10'd0 && lastY == 7) begin
          checkOutput("y_wrap_posx", 32'(sPosX), 0);
          checkOutput("y_wrap_prev_x", 32'(lastX), 14);
        end
        lastX = int'(sPosX);
        lastY = int'(sPosY);
        phase = 0;
      end else begin
        phase++;
      end
      if (phase == 2) begin
        if (!sHSync) sHLow++;
        if (!sVSync) begin
          sVLow++;
          if (vFirst < 0) vFirst = lastY;
          vLast = lastY;
        end
        if (sVideoOn) sVideo++;
      end
    end
    checkOutput("small_fs_count", 32'(fsCount), 2);
    checkOutput("small_fs1_cycle", 32'(fs1), 360);
    checkOutput("small_fs2_cycle", 32'(fs2), 720);
    checkOutput("small_hsync_ticks", 32'(sHLow), 48);
    checkOutput("small_vsync_ticks", 32'(sVLow), 60);
    checkOutput("small_vsync_first_y", 32'(vFirst), 5);
    checkOutput("small_vsync_last_y", 32'(vLast), 6);
    checkOutput("small_video_ticks", 32'(sVideo), 64);

    #3 rst = 1'b0;
    #1;
    checkOutput("small_async_posx", 32'(sPosX), 14);
    checkOutput("small_async_posy", 32'(sPosY), 7);
    checkOutput("small_async_vsync", 32'(sVSync), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
